// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared FSM states, ALU opcodes and trap constants for the ALU round-robin scheduler
package alu_sched_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_MAX = OP_DIV;
  localparam logic [7:0] TRAP_DATA = 8'h00;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);
  logic [ID_W-1:0] j;
  always_comb begin
    grant = '0;
    idx = '0;
    any = 1'b0;
    j = '0;
    // walk backwards so the lowest offset from ptr is assigned last and wins
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one registered ALU among NUM_REQ requesters
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W = 4,
  parameter int ID_W = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  input  logic [NUM_REQ*SEL_W-1:0]   req_sel,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  output logic [SEL_W-1:0]           alu_sel,
  input  logic [DATA_W-1:0]          alu_out,
  input  logic                       alu_carry,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_carry,
  output logic                       rsp_err,
  output logic                       busy
);
  state_t state, state_n;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0] gidx, rr_ptr, op_id;
  logic any, trap, accept;
  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];
  logic [SEL_W-1:0] s_arr [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*DATA_W +: DATA_W];
    assign b_arr[i] = req_b[i*DATA_W +: DATA_W];
    assign s_arr[i] = req_sel[i*SEL_W +: SEL_W];
  end
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(gidx),
    .any(any)
  );
  assign trap = (s_arr[gidx] > SEL_W'(OP_MAX)) || (s_arr[gidx] == SEL_W'(OP_DIV) && b_arr[gidx] == '0);
  assign accept = state == IDLE && any && !reset;
  assign req_ready = accept ? grant : '0;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (any ? (trap ? RESP : EXEC) : IDLE) :
              (state == EXEC) ? CAPT :
              (state == CAPT) ? RESP :
              (rsp_ready ? IDLE : RESP);
  end
  // trapped ops never load the ALU registers, so the ALU cannot see them
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      op_id <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      rsp_id <= '0;
      rsp_data <= '0;
      rsp_carry <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_id <= gidx;
        rsp_id <= gidx;
        if (trap) begin
          rsp_data <= DATA_W'(TRAP_DATA);
          rsp_carry <= 1'b0;
          rsp_err <= 1'b1;
        end else begin
          alu_a <= a_arr[gidx];
          alu_b <= b_arr[gidx];
          alu_sel <= s_arr[gidx];
        end
      end
      if (state == CAPT) begin
        rsp_data <= alu_out;
        rsp_carry <= alu_sel == SEL_W'(OP_ADD) && alu_carry;
        rsp_err <= 1'b0;
      end
      if (state == RESP && rsp_ready) rr_ptr <= (op_id == ID_W'(NUM_REQ - 1)) ? '0 : op_id + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: scoreboard bench with a behavioural ALU, directed cases and random traffic
module tb_alu_rr_scheduler;
  import alu_sched_pkg::*;
  localparam int N = 4;
  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic carry;
    logic err;
    logic trap;
    int tacc;
  } rsp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*8-1:0] req_a = '0;
  logic [N*8-1:0] req_b = '0;
  logic [N*4-1:0] req_sel = '0;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_out = '0;
  logic [3:0] alu_sel;
  logic alu_carry = 1'b0;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [1:0] rsp_id;
  logic [7:0] rsp_data;
  logic rsp_carry, rsp_err, busy;
  logic [8:0] alu_n;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int mptr = 0;
  rsp_t exp_q[$];

  alu_rr_scheduler #(.NUM_REQ(N), .DATA_W(8), .SEL_W(4), .ID_W(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // registered ALU; SUB reports borrow on carry so the ADD-only gating is exercised
  always_comb begin
    alu_n = 9'd0;
    alu_n = (alu_sel == 4'd0) ? {1'b0, alu_a} + {1'b0, alu_b} :
            (alu_sel == 4'd1) ? {1'b0, alu_a} - {1'b0, alu_b} :
            (alu_sel == 4'd2) ? {1'b0, 8'(alu_a * alu_b)} :
            (alu_sel == 4'd3 && alu_b != 8'd0) ? {1'b0, alu_a / alu_b} : 9'd0;
  end
  always @(posedge clock) begin
    alu_out <= alu_n[7:0];
    alu_carry <= alu_n[8];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at cycle %0d", nm, act, want, cyc);
    end
  endtask

  function automatic rsp_t model(input int id, input int a, input int b, input int sel, input int t);
    rsp_t m;
    m.id = 2'(id);
    m.tacc = t;
    m.trap = sel > 3 || (sel == 3 && b == 0);
    m.err = m.trap;
    m.carry = 1'b0;
    m.data = 8'd0;
    if (!m.trap) begin
      case (sel)
        0: begin m.data = 8'((a + b) % 256); m.carry = (a + b) > 255; end
        1: m.data = 8'((a - b + 256) % 256);
        2: m.data = 8'((a * b) % 256);
        default: m.data = 8'(a / b);
      endcase
    end
    return m;
  endfunction

  function automatic int pick();
    for (int k = 0; k < N; k++) if (req_valid[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_sel[i*4 +: 4] = s;
    req_valid[i] = 1'b1;
  endtask

  // one cycle: observe grant at negedge, record expectation, retire the granted request after the edge
  task automatic step();
    int g;
    rsp_t e;
    g = -1;
    @(negedge clock);
    if (!reset) begin
      if (busy) chk("ready_while_busy", req_ready, 0);
      else if (|req_valid) begin
        g = pick();
        chk("grant", req_ready, 64'(1) << g);
        e = model(g, int'(req_a[g*8 +: 8]), int'(req_b[g*8 +: 8]), int'(req_sel[g*4 +: 4]), cyc);
        exp_q.push_back(e);
      end
    end
    @(posedge clock);
    #1;
    if (g >= 0) req_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy || |req_valid) && n < lim) begin
      step();
      n++;
    end
    if (n >= lim) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout after %0d cycles, pending %0d", n, exp_q.size());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    mptr = 0;
  endtask

  function automatic logic [63:0] outs();
    return 64'({req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err, busy});
  endfunction

  // monitor: latency, stability while stalled, ALU safety and response scoreboard
  initial begin
    rsp_t e;
    logic hold, pv;
    logic [10:0] prev;
    hold = 1'b0;
    pv = 1'b0;
    prev = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        hold = 1'b0;
        pv = 1'b0;
      end else begin
        if (alu_sel == 4'd3) chk("div_operand_nonzero", 64'(alu_b != 8'd0), 1);
        if (hold && rsp_valid) chk("rsp_stable", {rsp_id, rsp_data, rsp_carry}, prev);
        if (rsp_valid && !pv) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp id %0d data %0h", rsp_id, rsp_data);
          end else begin
            e = exp_q[0];
            chk("latency", cyc - e.tacc, e.trap ? 1 : 3);
          end
        end
        if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp", {rsp_id, rsp_data, rsp_carry, rsp_err}, {e.id, e.data, e.carry, e.err});
          mptr = (int'(e.id) + 1) % N;
        end
        hold = rsp_valid && !rsp_ready;
        prev = {rsp_id, rsp_data, rsp_carry};
        pv = rsp_valid;
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("reset_outputs", outs(), 0);
    @(posedge clock);
    #1;
    issue(0, 8'hF0, 8'h20, OP_ADD);
    wait_idle(20);
    do_reset();
    issue(0, 8'h7F, 8'h01, OP_ADD);
    issue(1, 8'h05, 8'h07, OP_SUB);
    issue(2, 8'h10, 8'h11, OP_MUL);
    issue(3, 8'h81, 8'h07, OP_DIV);
    wait_idle(60);
    issue(2, 8'h40, 8'h00, OP_DIV);
    wait_idle(20);
    issue(3, 8'h12, 8'h34, 4'h9);
    wait_idle(20);
    issue(1, 8'h10, 8'h11, OP_MUL);
    wait_idle(20);
    rsp_ready = 1'b0;
    issue(0, 8'h07, 8'h09, OP_ADD);
    step();
    issue(2, 8'h01, 8'h01, OP_ADD);
    for (int k = 0; k < 10 && !rsp_valid; k++) step();
    chk("stall_rsp_valid", rsp_valid, 1);
    repeat (5) begin
      step();
      chk("stall_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    wait_idle(30);
    issue(1, 8'h03, 8'h04, OP_SUB);
    wait_idle(20);
    issue(1, 8'h33, 8'h22, OP_ADD);
    step();
    chk("pre_reset_accept", exp_q.size(), 1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    mptr = 0;
    @(negedge clock);
    chk("reset_in_capt", outs(), 0);
    @(posedge clock);
    #1;
    issue(2, 8'h02, 8'h03, OP_MUL);
    issue(0, 8'h09, 8'h03, OP_DIV);
    wait_idle(30);
    repeat (400) begin
      step();
      rsp_ready = $urandom_range(3) != 0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(2) == 0)
          issue(i, 8'($urandom_range(255)), ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom_range(255)),
                ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(3)));
        else if (req_valid[i] && $urandom_range(19) == 0)
          req_valid[i] = 1'b0;
      end
    end
    rsp_ready = 1'b1;
    wait_idle(100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
